// File: rtl/traffic_light_ctrl.sv
// Two-way intersection controller: NS/EW phases with per-phase tick durations,
// a tick prescaler, pedestrian early-green-exit and a night flashing-yellow mode.
module traffic_light_ctrl #(
    parameter int GREEN_T     = 5,
    parameter int MIN_GREEN_T = 2,
    parameter int YELLOW_T    = 1,
    parameter int ALLRED_T    = 1,
    parameter int TICK_DIV    = 1,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ped_req,
    input  logic             night,
    output logic [2:0]       north_south,
    output logic [2:0]       east_west,
    output logic [CNT_W-1:0] time_left,
    output logic             ped_ack
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] G_LOAD  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] Y_LOAD  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] R_LOAD  = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] PED_LIM = CNT_W'(GREEN_T - MIN_GREEN_T);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;
    localparam logic [2:0] LAMP_DARK   = 3'b000;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_A     = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_B     = 3'd5,
        FLASH     = 3'd6
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic [PW-1:0]    presc, presc_n;
    logic             ped_pend, ped_pend_n;
    logic             flash, flash_n;
    logic             ack_n;
    logic             tick;

    function automatic logic [2:0] ns_lamp(input state_t s, input logic f);
        case (s)
            NS_GREEN:  ns_lamp = LAMP_GREEN;
            NS_YELLOW: ns_lamp = LAMP_YELLOW;
            FLASH:     ns_lamp = f ? LAMP_YELLOW : LAMP_DARK;
            default:   ns_lamp = LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input state_t s, input logic f);
        case (s)
            EW_GREEN:  ew_lamp = LAMP_GREEN;
            EW_YELLOW: ew_lamp = LAMP_YELLOW;
            FLASH:     ew_lamp = f ? LAMP_YELLOW : LAMP_DARK;
            default:   ew_lamp = LAMP_RED;
        endcase
    endfunction

    assign tick = (presc == PRE_MAX);

    // Next-state logic; a request seen on the green exit clock is consumed by it
    always_comb begin
        state_n    = state;
        timer_n    = timer;
        flash_n    = flash;
        ack_n      = 1'b0;
        presc_n    = tick ? '0 : presc + PW'(1);
        ped_pend_n = ped_pend | (ped_req && (state != FLASH));
        if (tick) begin
            case (state)
                NS_GREEN, EW_GREEN: begin
                    if ((timer == '0) || (ped_pend && (timer <= PED_LIM))) begin
                        state_n    = (state == NS_GREEN) ? NS_YELLOW : EW_YELLOW;
                        timer_n    = Y_LOAD;
                        ack_n      = ped_pend | ped_req;
                        ped_pend_n = 1'b0;
                    end else begin
                        timer_n = timer - CNT_W'(1);
                    end
                end
                NS_YELLOW, EW_YELLOW: begin
                    if (timer == '0) begin
                        state_n = (state == NS_YELLOW) ? RED_A : RED_B;
                        timer_n = R_LOAD;
                    end else begin
                        timer_n = timer - CNT_W'(1);
                    end
                end
                RED_A, RED_B: begin
                    if (timer != '0) begin
                        timer_n = timer - CNT_W'(1);
                    end else if (night) begin
                        state_n    = FLASH;
                        timer_n    = '0;
                        flash_n    = 1'b1;
                        ped_pend_n = 1'b0;
                    end else begin
                        state_n = (state == RED_A) ? EW_GREEN : NS_GREEN;
                        timer_n = G_LOAD;
                    end
                end
                FLASH: begin
                    flash_n = ~flash;
                    if (!night) begin
                        state_n = RED_B;
                        timer_n = R_LOAD;
                    end else begin
                        timer_n = '0;
                    end
                end
                default: begin
                    state_n    = NS_GREEN;
                    timer_n    = G_LOAD;
                    ped_pend_n = 1'b0;
                end
            endcase
        end else begin
            timer_n = timer;
        end
    end

    // State registers plus outputs decoded from the next state so they stay registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= NS_GREEN;
            timer       <= G_LOAD;
            presc       <= '0;
            ped_pend    <= 1'b0;
            flash       <= 1'b1;
            north_south <= LAMP_GREEN;
            east_west   <= LAMP_RED;
            time_left   <= G_LOAD;
            ped_ack     <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            presc       <= presc_n;
            ped_pend    <= ped_pend_n;
            flash       <= flash_n;
            north_south <= ns_lamp(state_n, flash_n);
            east_west   <= ew_lamp(state_n, flash_n);
            time_left   <= (state_n == FLASH) ? '0 : timer_n;
            ped_ack     <= ack_n;
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: default timing, pedestrian shortening,
// night flashing, mid-phase reset, and a slowed-tick instance.
module tb_traffic_light_ctrl;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] Y = 3'b001;
    localparam logic [2:0] D = 3'b000;

    logic       clk = 1'b0;
    logic       rst, ped_req, night;
    logic [2:0] ns, ew;
    logic [3:0] tl;
    logic       ack;
    logic       rst2, ped_req2, night2;
    logic [2:0] ns2, ew2;
    logic [3:0] tl2;
    logic       ack2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl dut (
        .clk(clk), .rst(rst), .ped_req(ped_req), .night(night),
        .north_south(ns), .east_west(ew), .time_left(tl), .ped_ack(ack)
    );

    traffic_light_ctrl #(.GREEN_T(3), .TICK_DIV(4)) dut2 (
        .clk(clk), .rst(rst2), .ped_req(ped_req2), .night(night2),
        .north_south(ns2), .east_west(ew2), .time_left(tl2), .ped_ack(ack2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input bit sel, input logic [2:0] ens,
                       input logic [2:0] eew, input logic [3:0] etl, input logic eack);
        logic [2:0] ons, oew;
        logic [3:0] otl;
        logic       oack;
        if (sel) begin
            ons = ns2; oew = ew2; otl = tl2; oack = ack2;
        end else begin
            ons = ns; oew = ew; otl = tl; oack = ack;
        end
        n_assert++;
        assert ({ons, oew, otl, oack} === {ens, eew, etl, eack}) else begin
            n_fail++;
            $error("FAIL %s t=%0t: observed ns=%b ew=%b tl=%0d ack=%b expected ns=%b ew=%b tl=%0d ack=%b",
                   tag, $time, ons, oew, otl, oack, ens, eew, etl, eack);
        end
    endtask

    // Check one phase clock by clock; time_left drops by one every div clocks
    task automatic run_phase(input string tag, input bit sel, input logic [2:0] ens,
                             input logic [2:0] eew, input int tl0, input int len,
                             input logic ack0, input int div);
        for (int k = 0; k < len; k++) begin
            chk(tag, sel, ens, eew, 4'(tl0 - k / div), (k == 0) ? ack0 : 1'b0);
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ped_req = 1'b0; night = 1'b0;
        rst2 = 1'b0; ped_req2 = 1'b0; night2 = 1'b0;
        step();

        // Default timing, three identical 14-clock periods
        do_reset();
        chk("reset", 1'b0, G, R, 4'd4, 1'b0);
        for (int p = 0; p < 3; p++) begin
            run_phase("p_nsg", 1'b0, G, R, 4, 5, 1'b0, 1);
            run_phase("p_nsy", 1'b0, Y, R, 0, 1, 1'b0, 1);
            run_phase("p_reda", 1'b0, R, R, 0, 1, 1'b0, 1);
            run_phase("p_ewg", 1'b0, R, G, 4, 5, 1'b0, 1);
            run_phase("p_ewy", 1'b0, R, Y, 0, 1, 1'b0, 1);
            run_phase("p_redb", 1'b0, R, R, 0, 1, 1'b0, 1);
        end
        chk("p_wrap", 1'b0, G, R, 4'd4, 1'b0);

        // Pedestrian pulse in the first clock after reset
        do_reset();
        ped_req = 1'b1;
        run_phase("ped1_nsg0", 1'b0, G, R, 4, 1, 1'b0, 1);
        ped_req = 1'b0;
        run_phase("ped1_nsg1", 1'b0, G, R, 3, 1, 1'b0, 1);
        run_phase("ped1_nsy", 1'b0, Y, R, 0, 1, 1'b1, 1);
        run_phase("ped1_reda", 1'b0, R, R, 0, 1, 1'b0, 1);
        run_phase("ped1_ewg", 1'b0, R, G, 4, 5, 1'b0, 1);
        run_phase("ped1_ewy", 1'b0, R, Y, 0, 1, 1'b0, 1);
        run_phase("ped1_redb", 1'b0, R, R, 0, 1, 1'b0, 1);
        run_phase("ped1_nsg", 1'b0, G, R, 4, 5, 1'b0, 1);

        // Request during NS yellow shortens EW green; one raised in RED_B shortens NS green
        ped_req = 1'b1;
        run_phase("ped2_nsy", 1'b0, Y, R, 0, 1, 1'b0, 1);
        ped_req = 1'b0;
        run_phase("ped2_reda", 1'b0, R, R, 0, 1, 1'b0, 1);
        run_phase("ped2_ewg", 1'b0, R, G, 4, 2, 1'b0, 1);
        run_phase("ped2_ewy", 1'b0, R, Y, 0, 1, 1'b1, 1);
        ped_req = 1'b1;
        run_phase("ped2_redb", 1'b0, R, R, 0, 1, 1'b0, 1);
        ped_req = 1'b0;
        run_phase("ped2_nsg", 1'b0, G, R, 4, 2, 1'b0, 1);
        run_phase("ped2_nsy2", 1'b0, Y, R, 0, 1, 1'b1, 1);
        run_phase("ped2_reda2", 1'b0, R, R, 0, 1, 1'b0, 1);
        run_phase("ped2_ewg2", 1'b0, R, G, 4, 5, 1'b0, 1);
        run_phase("ped2_ewy2", 1'b0, R, Y, 0, 1, 1'b0, 1);
        run_phase("ped2_redb2", 1'b0, R, R, 0, 1, 1'b0, 1);

        // Night raised mid EW green, flashing, ped ignored, then back to day
        run_phase("n_nsg", 1'b0, G, R, 4, 5, 1'b0, 1);
        run_phase("n_nsy", 1'b0, Y, R, 0, 1, 1'b0, 1);
        run_phase("n_reda", 1'b0, R, R, 0, 1, 1'b0, 1);
        run_phase("n_ewg_a", 1'b0, R, G, 4, 2, 1'b0, 1);
        night = 1'b1;
        run_phase("n_ewg_b", 1'b0, R, G, 2, 3, 1'b0, 1);
        run_phase("n_ewy", 1'b0, R, Y, 0, 1, 1'b0, 1);
        run_phase("n_redb", 1'b0, R, R, 0, 1, 1'b0, 1);
        run_phase("n_flash0", 1'b0, Y, Y, 0, 1, 1'b0, 1);
        ped_req = 1'b1;
        run_phase("n_flash1", 1'b0, D, D, 0, 1, 1'b0, 1);
        run_phase("n_flash2", 1'b0, Y, Y, 0, 1, 1'b0, 1);
        ped_req = 1'b0;
        night = 1'b0;
        run_phase("n_flash3", 1'b0, D, D, 0, 1, 1'b0, 1);
        run_phase("n_exit_redb", 1'b0, R, R, 0, 1, 1'b0, 1);
        run_phase("n_nsg_full", 1'b0, G, R, 4, 5, 1'b0, 1);
        run_phase("n_nsy2", 1'b0, Y, R, 0, 1, 1'b0, 1);
        run_phase("n_reda2", 1'b0, R, R, 0, 1, 1'b0, 1);
        run_phase("n_ewg2", 1'b0, R, G, 4, 5, 1'b0, 1);

        // Reset mid EW yellow
        chk("r_ewy", 1'b0, R, Y, 4'd0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run_phase("r1_nsg", 1'b0, G, R, 4, 5, 1'b0, 1);
        night = 1'b1;
        run_phase("r1_nsy", 1'b0, Y, R, 0, 1, 1'b0, 1);
        run_phase("r1_reda", 1'b0, R, R, 0, 1, 1'b0, 1);

        // Reset during FLASH
        chk("r_flash", 1'b0, Y, Y, 4'd0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        night = 1'b0;
        run_phase("r2_nsg", 1'b0, G, R, 4, 5, 1'b0, 1);
        run_phase("r2_nsy", 1'b0, Y, R, 0, 1, 1'b0, 1);
        run_phase("r2_reda", 1'b0, R, R, 0, 1, 1'b0, 1);

        // Prescaled instance: GREEN_T=3, TICK_DIV=4, 40-clock period
        rst2 = 1'b1;
        step();
        rst2 = 1'b0;
        for (int p = 0; p < 2; p++) begin
            run_phase("d4_nsg", 1'b1, G, R, 2, 12, 1'b0, 4);
            run_phase("d4_nsy", 1'b1, Y, R, 0, 4, 1'b0, 4);
            run_phase("d4_reda", 1'b1, R, R, 0, 4, 1'b0, 4);
            run_phase("d4_ewg", 1'b1, R, G, 2, 12, 1'b0, 4);
            run_phase("d4_ewy", 1'b1, R, Y, 0, 4, 1'b0, 4);
            run_phase("d4_redb", 1'b1, R, R, 0, 4, 1'b0, 4);
        end
        chk("d4_wrap", 1'b1, G, R, 4'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
